// File: rtl/ldtu_enc_pkg.sv
// Shared constants for the LiTe-DTU lossless encoder: word header codes,
// sync patterns, FSM state encoding and field-width helpers.
package ldtu_enc_pkg;

    localparam logic [1:0]  HDR_FULL_BAS = 2'b01;
    localparam logic [1:0]  HDR_PART_BAS = 2'b10;
    localparam logic [5:0]  HDR_PAIR     = 6'b001010;
    localparam logic [5:0]  HDR_SINGLE   = 6'b001011;

    localparam int          SYNC_W       = 13;
    localparam logic [12:0] SYNC         = 13'b0101010101010;
    localparam logic [12:0] HEADER_SYNCH = 13'b1111000001111;

    localparam int FULL_HDR_W = 2;
    localparam int PART_HDR_W = 8;
    localparam int SIG_HDR_W  = 6;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BAS  = 2'd1;
    localparam logic [1:0] ST_SIG1 = 2'd2;

    // Zero-pad width between a word header and its LSB-aligned payload.
    function automatic int pad_w(input int w_out, input int hdr_w, input int used_w);
        return w_out - hdr_w - used_w;
    endfunction

endpackage

// File: rtl/ldtu_enc_ofifo.sv
// Output word FIFO with two ordered write ports and one read port. The head
// word is held in a register so it keeps its last value while empty.
module ldtu_enc_ofifo #(
    parameter int W     = 32,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_b,
    input  logic                       wr_en0,
    input  logic [W-1:0]               wr_data0,
    input  logic                       wr_en1,
    input  logic [W-1:0]               wr_data1,
    input  logic                       rd_en,
    output logic [W-1:0]               rd_data,
    output logic                       not_empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic [$clog2(DEPTH):0]     free
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg, wr_ptr_next, wr_ptr_plus1;
    logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
    logic [CW-1:0] count_reg, count_next;
    logic [W-1:0]  data_reg, data_next;
    logic          pop;

    assign pop          = rd_en && (count_reg != '0);
    assign wr_ptr_plus1 = wr_ptr_reg + 1'b1;

    always_comb begin
        rd_ptr_next = rd_ptr_reg + AW'(pop);
        wr_ptr_next = wr_ptr_reg + AW'(wr_en0) + AW'(wr_en1);
        count_next  = count_reg - CW'(pop) + CW'(wr_en0) + CW'(wr_en1);
        data_next   = data_reg;
        // The new head may be a word being written this very cycle.
        if (count_next != '0) begin
            if (wr_en0 && (rd_ptr_next == wr_ptr_reg))
                data_next = wr_data0;
            else if (wr_en1 && (rd_ptr_next == wr_ptr_plus1))
                data_next = wr_data1;
            else
                data_next = mem[rd_ptr_next];
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en0)
            mem[wr_ptr_reg] <= wr_data0;
        if (wr_en1)
            mem[wr_ptr_plus1] <= wr_data1;
    end

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            data_reg   <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
            data_reg   <= data_next;
        end
    end

    assign rd_data   = data_reg;
    assign not_empty = (count_reg != '0);
    assign count     = count_reg;
    assign free      = CW'(DEPTH) - count_reg;

endmodule

// File: rtl/ldtu_encoder_nch.sv
// LiTe-DTU next-generation lossless encoder: packs baseline and signal samples
// into output words, inserts orbit headers and buffers words for the serializer.
module ldtu_encoder_nch
    import ldtu_enc_pkg::*;
#(
    parameter int NB_SIG     = 13,
    parameter int NB_BAS     = 6,
    parameter int W_OUT      = 32,
    parameter int N_BAS      = 5,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          CLK,
    input  logic                          rst_b,
    input  logic [NB_SIG-1:0]             DATA_in,
    input  logic                          DATA_valid,
    input  logic                          baseline_flag,
    input  logic                          Orbit,
    input  logic                          Ready,
    output logic [W_OUT-1:0]              DATA_32,
    output logic                          Load,
    output logic                          Overflow,
    output logic [$clog2(FIFO_DEPTH):0]   Fill
);

    localparam int FW           = $clog2(FIFO_DEPTH) + 1;
    localparam int BAS_W        = N_BAS * NB_BAS;
    localparam int FULL_FIELD_W = pad_w(W_OUT, FULL_HDR_W, BAS_W) + BAS_W;
    localparam int PART_FIELD_W = pad_w(W_OUT, PART_HDR_W, BAS_W) + BAS_W;
    localparam int PAIR_FIELD_W = pad_w(W_OUT, SIG_HDR_W, 2 * NB_SIG) + 2 * NB_SIG;
    localparam int SYNC_FIELD_W = pad_w(W_OUT, SIG_HDR_W, SYNC_W + NB_SIG) + SYNC_W + NB_SIG;

    logic [1:0]        state_reg, state_next;
    logic [5:0]        cnt_reg, cnt_next;
    logic [BAS_W-1:0]  bas_reg, bas_next, bas_ins;
    logic [NB_SIG-1:0] sig_reg, sig_next;
    logic              overflow_reg, overflow_next;

    logic [W_OUT-1:0]  full_word, part_word, pair_word, single_word, hdr_word;
    logic [W_OUT-1:0]  word0, word1;
    logic [1:0]        n_push;
    logic              pop, accept, fifo_not_empty;
    logic [FW-1:0]     fifo_free, free_after, fifo_count;

    // Accumulator with the incoming baseline placed in slot cnt_reg.
    for (genvar gi = 0; gi < N_BAS; gi++) begin : g_bas_slot
        assign bas_ins[gi*NB_BAS +: NB_BAS] = (cnt_reg == 6'(gi)) ? DATA_in[NB_BAS-1:0]
                                                                  : bas_reg[gi*NB_BAS +: NB_BAS];
    end

    assign full_word   = {HDR_FULL_BAS, FULL_FIELD_W'(bas_ins)};
    assign part_word   = {HDR_PART_BAS, cnt_reg, PART_FIELD_W'(bas_reg)};
    assign pair_word   = {HDR_PAIR, PAIR_FIELD_W'({DATA_in, sig_reg})};
    assign single_word = {HDR_SINGLE, SYNC_FIELD_W'({SYNC, sig_reg})};
    assign hdr_word    = {HDR_SINGLE, SYNC_FIELD_W'({HEADER_SYNCH, {NB_SIG{1'b0}}})};

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        bas_next   = bas_reg;
        sig_next   = sig_reg;
        n_push     = 2'd0;
        word0      = '0;
        word1      = '0;
        if (Orbit) begin
            // Flush, then header; a same-cycle sample starts a fresh accumulator.
            if (state_reg == ST_BAS) begin
                word0  = part_word;
                word1  = hdr_word;
                n_push = 2'd2;
            end else if (state_reg == ST_SIG1) begin
                word0  = single_word;
                word1  = hdr_word;
                n_push = 2'd2;
            end else begin
                word0  = hdr_word;
                n_push = 2'd1;
            end
            state_next = ST_IDLE;
            cnt_next   = '0;
            bas_next   = '0;
            if (DATA_valid && baseline_flag) begin
                state_next = ST_BAS;
                cnt_next   = 6'd1;
                bas_next   = BAS_W'(DATA_in[NB_BAS-1:0]);
            end else if (DATA_valid) begin
                state_next = ST_SIG1;
                sig_next   = DATA_in;
            end
        end else if (DATA_valid) begin
            if (baseline_flag) begin
                if (state_reg == ST_SIG1) begin
                    word0      = single_word;
                    n_push     = 2'd1;
                    state_next = ST_BAS;
                    cnt_next   = 6'd1;
                    bas_next   = BAS_W'(DATA_in[NB_BAS-1:0]);
                end else if (cnt_reg == 6'(N_BAS - 1)) begin
                    word0      = full_word;
                    n_push     = 2'd1;
                    state_next = ST_IDLE;
                    cnt_next   = '0;
                    bas_next   = '0;
                end else begin
                    state_next = ST_BAS;
                    cnt_next   = cnt_reg + 6'd1;
                    bas_next   = bas_ins;
                end
            end else begin
                if (state_reg == ST_BAS) begin
                    word0      = part_word;
                    n_push     = 2'd1;
                    state_next = ST_SIG1;
                    cnt_next   = '0;
                    bas_next   = '0;
                    sig_next   = DATA_in;
                end else if (state_reg == ST_SIG1) begin
                    word0      = pair_word;
                    n_push     = 2'd1;
                    state_next = ST_IDLE;
                end else begin
                    state_next = ST_SIG1;
                    sig_next   = DATA_in;
                end
            end
        end
    end

    // All of a cycle's pushes are dropped together when they do not fit.
    assign pop           = fifo_not_empty && Ready;
    assign free_after    = fifo_free + FW'(pop);
    assign accept        = (FW'(n_push) <= free_after);
    assign overflow_next = overflow_reg | ~accept;

    always_ff @(posedge CLK) begin
        if (!rst_b) begin
            state_reg    <= ST_IDLE;
            cnt_reg      <= '0;
            bas_reg      <= '0;
            sig_reg      <= '0;
            overflow_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            bas_reg      <= bas_next;
            sig_reg      <= sig_next;
            overflow_reg <= overflow_next;
        end
    end

    ldtu_enc_ofifo #(
        .W     (W_OUT),
        .DEPTH (FIFO_DEPTH)
    ) u_ofifo (
        .clk       (CLK),
        .rst_b     (rst_b),
        .wr_en0    (accept && (n_push != 2'd0)),
        .wr_data0  (word0),
        .wr_en1    (accept && (n_push == 2'd2)),
        .wr_data1  (word1),
        .rd_en     (Ready),
        .rd_data   (DATA_32),
        .not_empty (fifo_not_empty),
        .count     (fifo_count),
        .free      (fifo_free)
    );

    assign Load     = fifo_not_empty;
    assign Overflow = overflow_reg;
    assign Fill     = fifo_count;

endmodule
